// File: rtl/crc32_stream.sv
// ----------------------------------------------------------------------------
// crc32_stream
//
// Streaming CRC generator/checker for the Ethernet MAC FCS paths. Accepts a
// framed byte stream (valid/ready, per-byte keep, first/last markers), folds
// up to DATA_BYTES bytes per beat into a 32-bit CRC register, and presents the
// final CRC plus a residue-match flag through a holding valid/ready handshake.
// Defaults give IEEE 802.3 CRC-32.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   s_valid       input beat valid
//   s_ready       block accepts a beat (low while a result is held)
//   s_data        input bytes, byte 0 = s_data[7:0] is first on the wire
//   s_keep        per-byte enables, contiguous from bit 0
//   s_first       first beat of a frame (restarts the CRC from INIT)
//   s_last        last beat of a frame
//   crc_valid     result available
//   crc_ready     consumer takes the result
//   crc_out       final CRC; crc_out[7:0] is the first FCS byte on the wire
//   crc_match     internal register equalled RESIDUE at end of frame
//   byte_count    bytes accumulated in the current/held frame (saturating)
//   busy          block is not idle
// ----------------------------------------------------------------------------
module crc32_stream #(
    parameter int unsigned DATA_BYTES  = 1,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter logic [31:0] RESIDUE     = 32'hC704DD7B
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_first,
    input  logic                    s_last,
    output logic                    crc_valid,
    input  logic                    crc_ready,
    output logic [31:0]             crc_out,
    output logic                    crc_match,
    output logic [15:0]             byte_count,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_crc;
    logic [31:0] r_crc_out;
    logic        r_crc_match;
    logic [15:0] r_byte_count;

    logic        w_accept;
    logic        w_take;
    logic [31:0] w_crc_base;
    logic [31:0] w_crc_next;
    logic [15:0] w_pop;
    logic [16:0] w_sum;
    logic [15:0] w_count_next;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

    // One byte through the MSB-first shift register. With REFLECT_IN the byte
    // is bit-reversed first so its LSB enters the register first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in,
                                             input logic [7:0]  d_in);
        logic [31:0] c;
        logic [7:0]  d;
        logic        fb;
        c = c_in;
        d = REFLECT_IN ? bitrev8(d_in) : d_in;
        for (int unsigned k = 0; k < 8; k++) begin
            fb = c[31] ^ d[7-k];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Beat acceptance
    // ------------------------------------------------------------------------
    assign w_accept = s_valid && s_ready;
    // Beats without s_first are dropped while idle; any accepted beat counts
    // while accumulating (s_first there restarts the frame).
    assign w_take   = w_accept && (s_first || (r_state == ST_ACCUM));

    assign w_crc_base = s_first ? INIT : r_crc;

    // Unrolled per-byte update in wire order; keep=0 bytes are skipped.
    always_comb begin
        w_crc_next = w_crc_base;
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            if (s_keep[b]) begin
                w_crc_next = crc_byte(w_crc_next, s_data[8*b +: 8]);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            w_pop = w_pop + 16'(s_keep[b]);
        end
    end

    // Running count saturates at 16'hFFFF rather than wrapping.
    assign w_sum        = {1'b0, r_byte_count} + {1'b0, w_pop};
    assign w_count_next = s_first ? w_pop
                                  : (w_sum[16] ? 16'hFFFF : w_sum[15:0]);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_next = s_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_take && s_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (crc_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        s_ready   = 1'b1;
        crc_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE:  busy      = 1'b0;
            ST_ACCUM: s_ready   = 1'b1;
            ST_HOLD: begin
                s_ready   = 1'b0;
                crc_valid = 1'b1;
            end
            default: begin
                s_ready = 1'b1;
                busy    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc        <= INIT;
            r_crc_out    <= '0;
            r_crc_match  <= 1'b0;
            r_byte_count <= '0;
        end else if (w_take) begin
            r_crc        <= w_crc_next;
            r_byte_count <= w_count_next;
            // Result is captured on the last beat so it is already stable
            // on the first HOLD cycle.
            if (s_last) begin
                r_crc_out   <= (REFLECT_OUT ? bitrev32(w_crc_next) : w_crc_next)
                               ^ XOR_OUT;
                r_crc_match <= (w_crc_next == RESIDUE);
            end
        end
    end

    assign crc_out    = r_crc_out;
    assign crc_match  = r_crc_match;
    assign byte_count = r_byte_count;

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
Parametrised, multi-byte-per-beat CRC generator/checker for the Ethernet MAC TX FCS-append and RX FCS-check paths. It accepts a framed byte stream with valid/ready and per-byte keep, and accumulates the CRC across beats. It presents the final CRC and a residue-match flag through a holding handshake. Polynomial, init, input/output reflection and final XOR are configurable; defaults give IEEE 802.3 CRC-32.

Parameters:
DATA_BYTES, 1, bytes per beat (1, 2, 4 or 8); byte 0 = s_data[7:0] is first on the wire
POLY, 32'h04C11DB7, generator polynomial, MSB-first form
INIT, 32'hFFFFFFFF, register value at frame start
XOR_OUT, 32'hFFFFFFFF, final XOR applied to crc_out
REFLECT_IN, 1, 1 = each input byte processed LSB-first
REFLECT_OUT, 1, 1 = 32-bit register bit-reversed before XOR_OUT
RESIDUE, 32'hC704DD7B, MSB-first internal register value that indicates a good frame+FCS

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input beat valid
s_ready  out  1  block accepts beat
s_data  in  8*DATA_BYTES  input bytes
s_keep  in  DATA_BYTES  byte enables; contiguous from bit 0
s_first  in  1  first beat of frame
s_last  in  1  last beat of frame
crc_valid  out  1  result available
crc_ready  in  1  consumer takes result
crc_out  out  32  final CRC; crc_out[7:0] is the first FCS byte on the wire
crc_match  out  1  internal register == RESIDUE at end of frame
byte_count  out  16  bytes accumulated in current/held frame
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ACCUM, HOLD. A beat is accepted when s_valid && s_ready.
- s_ready = 1 in IDLE and ACCUM; 0 in HOLD.
- Reset: state=IDLE; register=INIT; crc_valid=0, crc_out=0, crc_match=0, byte_count=0, busy=0. Reset mid-frame or mid-HOLD discards everything; the result is never presented.
- IDLE: an accepted beat with s_first loads the register from INIT, processes the beat, and sets byte_count = popcount(keep). Next state is ACCUM, or HOLD if s_last is set. An accepted beat without s_first in IDLE is dropped (no state change).
- ACCUM: an accepted beat updates the register and adds popcount(keep) to byte_count, saturating at 16'hFFFF. If s_first is set in ACCUM, the frame restarts from INIT with this beat. s_last moves to HOLD.
- Update: bytes 0..N-1 with keep=1 are processed serially in index order within one cycle (combinational unrolled loop). keep=0 bytes are skipped. Non-last beats are processed per their keep (not forced full).
- keep=0 on a last beat is legal; the beat adds no bytes. A zero-length frame gives crc_out = reflect?(INIT)^XOR_OUT = 32'h00000000 by default.
- Latency: crc_valid, crc_out, crc_match and final byte_count are registered and valid the cycle after the s_last beat is accepted.
- HOLD: crc_valid=1 and outputs stable until crc_valid && crc_ready. On that cycle: next state IDLE, crc_valid=0 next cycle, s_ready=1 next cycle. crc_ready has no effect when crc_valid=0.
- crc_out = (REFLECT_OUT ? bitrev32(reg) : reg) ^ XOR_OUT.
- crc_match compares the pre-reflect/pre-XOR register.

Test Plan:
- DATA_BYTES=1, "123456789" (0x31..0x39), first on 0x31, last on 0x39, crc_ready=1 -> crc_out=32'hCBF43926, byte_count=9, crc_valid one cycle after last.
- DATA_BYTES=4, same string as 3 beats, last keep=4'b0001 -> crc_out=32'hCBF43926, byte_count=9. Then the frame "123456789" followed by 26 39 F4 CB -> crc_match=1; flipping any one bit -> crc_match=0.
- HOLD backpressure: crc_ready low 5 cycles after frame -> crc_valid held, crc_out stable, s_ready=0, offered beats not accepted. crc_ready high -> one handshake, IDLE.
- Zero-length frame: single beat, first+last, keep=0 -> crc_out=32'h00000000, byte_count=0.
- Restart: s_first asserted mid-frame, then "123456789" -> crc_out=32'hCBF43926. rst for 1 cycle mid-frame -> all outputs at reset values, no crc_valid.
- Random s_valid gaps, DATA_BYTES=8, 64-byte frames vs a reference model -> all CRCs match. Back-to-back frames with crc_ready=1 -> no beats lost.
